addr_reg_bank: RTL and testbench

Parametrised bank of address-width registers for the relay computer model, generalising the single 8-bit load/select register. Each register loads from the 8-bit data bus (low or high byte), loads a whole address, drives the address bus, or self-increments. Every operation is gated by a programmable relay-settle delay and a valid/ready/done handshake. The bank sits between the control sequencer (control bus) and the address bus, and mirrors its load/select lines to the LED bus.

---
 rtl/relay_pkg.sv | 25 ++
 rtl/settle_timer.sv | 29 ++
 rtl/addr_reg_bank.sv | 142 ++++++++++++++
 tb/tb_addr_reg_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// rtl/relay_pkg.sv - shared types for the relay computer register blocks
package relay_pkg;

  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    LOAD_LO   = 3'd0,
    LOAD_HI   = 3'd1,
    LOAD_ADDR = 3'd2,
    SEL       = 3'd3,
    INC       = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EXEC   = 2'd2
  } state_e;

  // Ops that write a register and therefore light the load LED.
  function automatic logic is_load_op(input logic [2:0] op);
    return (op == LOAD_LO) || (op == LOAD_HI) || (op == LOAD_ADDR) || (op == INC);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - relay settle down-counter, expired while the count is zero
module settle_timer
  import relay_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/addr_reg_bank.sv
// rtl/addr_reg_bank.sv - bank of address registers with relay-settle handshake
// Loads from data/address bus, self-increments, drives the address bus and mirrors LEDs.
module addr_reg_bank
  import relay_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 16,
  parameter int NREGS  = 4,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [$clog2(NREGS)-1:0] req_idx,
  input  logic [DW-1:0]            data_in,
  input  logic [AW-1:0]            addr_in,
  output logic [AW-1:0]            addr_out,
  output logic                     addr_oe,
  output logic                     done,
  output logic                     err,
  output logic [NREGS-1:0]         led_ld,
  output logic [NREGS-1:0]         led_sel
);

  localparam int IW = $clog2(NREGS);
  localparam logic [IW:0] NR = (IW + 1)'(NREGS);
  localparam logic [SETTLE_W-1:0] LOADV = (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);

  if (AW != 2 * DW) begin : g_bad_aw
    $error("addr_reg_bank: AW must equal 2*DW");
  end
  if ((NREGS < 2) || (NREGS > 16)) begin : g_bad_nregs
    $error("addr_reg_bank: NREGS must be 2..16");
  end
  if ((SETTLE < 0) || (SETTLE > 15)) begin : g_bad_settle
    $error("addr_reg_bank: SETTLE must be 0..15");
  end

  state_e          st;
  logic [AW-1:0]   regs [NREGS];
  logic [2:0]      op_q;
  logic [IW-1:0]   idx_q;
  logic [DW-1:0]   data_q;
  logic [AW-1:0]   addr_q;
  logic            bad_q;

  logic            fire;
  logic            req_bad;
  logic            sel_ok;
  logic            ld_ok;
  logic            expired;
  logic [NREGS-1:0] idx_oh;

  assign fire    = req_valid && req_ready;
  assign req_bad = (req_op > 3'(INC)) || ({1'b0, req_idx} >= NR);
  assign sel_ok  = !req_bad && (req_op == SEL);
  assign ld_ok   = !req_bad && is_load_op(req_op);
  assign idx_oh  = NREGS'(1) << req_idx;

  settle_timer #(.W(SETTLE_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (fire),
    .load_val (LOADV),
    .en       (st == relay_pkg::SETTLE),
    .expired  (expired)
  );

  // Outputs are set on accept and held until the clock edge that ends EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      addr_oe   <= 1'b0;
      addr_out  <= '0;
      led_ld    <= '0;
      led_sel   <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      bad_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (st)
        IDLE: begin
          if (fire) begin
            op_q      <= req_op;
            idx_q     <= req_idx;
            data_q    <= data_in;
            addr_q    <= addr_in;
            bad_q     <= req_bad;
            req_ready <= 1'b0;
            addr_oe   <= sel_ok;
            addr_out  <= sel_ok ? regs[req_idx] : '0;
            led_ld    <= ld_ok ? idx_oh : '0;
            led_sel   <= sel_ok ? idx_oh : '0;
            if (SETTLE == 0) begin
              st   <= EXEC;
              done <= 1'b1;
              err  <= req_bad;
            end else begin
              st <= relay_pkg::SETTLE;
            end
          end
        end
        relay_pkg::SETTLE: begin
          if (expired) begin
            st   <= EXEC;
            done <= 1'b1;
            err  <= bad_q;
          end
        end
        EXEC: begin
          if (!bad_q) begin
            case (op_q)
              3'(LOAD_LO):   regs[idx_q][DW-1:0]  <= data_q;
              3'(LOAD_HI):   regs[idx_q][AW-1:DW] <= data_q;
              3'(LOAD_ADDR): regs[idx_q]          <= addr_q;
              3'(INC):       regs[idx_q]          <= regs[idx_q] + AW'(1);
              default: ;
            endcase
          end
          st        <= IDLE;
          req_ready <= 1'b1;
          addr_oe   <= 1'b0;
          addr_out  <= '0;
          led_ld    <= '0;
          led_sel   <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_reg_bank.sv
// tb/tb_addr_reg_bank.sv - directed table-driven bench for addr_reg_bank
module tb_addr_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  req_op;
  logic [1:0]  req_idx;
  logic [7:0]  data_in;
  logic [15:0] addr_in;

  logic valid_a, valid_b, valid_z;
  logic rdy_a, rdy_b, rdy_z, done_a, done_b, done_z, err_a, err_b, err_z, oe_a, oe_b, oe_z;
  logic [15:0] aout_a, aout_b, aout_z;
  logic [3:0] ld_a, sel_a, ld_z, sel_z;
  logic [2:0] ld_b, sel_b;

  // a: NREGS=4 SETTLE=2, b: NREGS=3 SETTLE=2, z: NREGS=4 SETTLE=0
  addr_reg_bank #(.DW(8), .AW(16), .NREGS(4), .SETTLE(2)) u_a (
    .clk(clk), .reset(reset), .req_valid(valid_a), .req_ready(rdy_a), .req_op(req_op),
    .req_idx(req_idx), .data_in(data_in), .addr_in(addr_in), .addr_out(aout_a),
    .addr_oe(oe_a), .done(done_a), .err(err_a), .led_ld(ld_a), .led_sel(sel_a));

  addr_reg_bank #(.DW(8), .AW(16), .NREGS(3), .SETTLE(2)) u_b (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_ready(rdy_b), .req_op(req_op),
    .req_idx(req_idx), .data_in(data_in), .addr_in(addr_in), .addr_out(aout_b),
    .addr_oe(oe_b), .done(done_b), .err(err_b), .led_ld(ld_b), .led_sel(sel_b));

  addr_reg_bank #(.DW(8), .AW(16), .NREGS(4), .SETTLE(0)) u_z (
    .clk(clk), .reset(reset), .req_valid(valid_z), .req_ready(rdy_z), .req_op(req_op),
    .req_idx(req_idx), .data_in(data_in), .addr_in(addr_in), .addr_out(aout_z),
    .addr_oe(oe_z), .done(done_z), .err(err_z), .led_ld(ld_z), .led_sel(sel_z));

  typedef struct {
    int          inst;
    logic [2:0]  op;
    logic [1:0]  idx;
    logic [7:0]  data;
    logic [15:0] addr;
    logic        e_err;
    logic        e_oe;
    logic [15:0] e_addr;
    logic [3:0]  e_ld;
    logic [3:0]  e_sel;
  } vec_t;

  vec_t tbl [$];
  int total = 0;
  int bad = 0;
  int dcount;

  logic s_ready, s_done, s_err, s_oe;
  logic [15:0] s_addr;
  logic [3:0] s_ld, s_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input int i);
    case (i)
      0: begin s_ready = rdy_a; s_done = done_a; s_err = err_a; s_oe = oe_a;
               s_addr = aout_a; s_ld = ld_a; s_sel = sel_a; end
      1: begin s_ready = rdy_b; s_done = done_b; s_err = err_b; s_oe = oe_b;
               s_addr = aout_b; s_ld = {1'b0, ld_b}; s_sel = {1'b0, sel_b}; end
      default: begin s_ready = rdy_z; s_done = done_z; s_err = err_z; s_oe = oe_z;
               s_addr = aout_z; s_ld = ld_z; s_sel = sel_z; end
    endcase
  endtask

  task automatic set_valid(input int i, input logic v);
    case (i)
      0: valid_a = v;
      1: valid_b = v;
      default: valid_z = v;
    endcase
  endtask

  function automatic vec_t mk(input int inst, input logic [2:0] op, input logic [1:0] idx,
                              input logic [7:0] d, input logic [15:0] a, input logic ee,
                              input logic eo, input logic [15:0] ea, input logic [3:0] el,
                              input logic [3:0] es);
    vec_t v;
    v.inst = inst; v.op = op; v.idx = idx; v.data = d; v.addr = a;
    v.e_err = ee; v.e_oe = eo; v.e_addr = ea; v.e_ld = el; v.e_sel = es;
    return v;
  endfunction

  // One op: accept, check every busy cycle, then the idle cycle after EXEC.
  task automatic run_op(input vec_t v, input string tag);
    int s;
    s = (v.inst == 2) ? 0 : 2;
    @(negedge clk);
    req_op = v.op; req_idx = v.idx; data_in = v.data; addr_in = v.addr;
    set_valid(v.inst, 1'b1);
    @(posedge clk);
    #1;
    set_valid(v.inst, 1'b0);
    req_op = 3'd2; req_idx = ~v.idx; data_in = ~v.data; addr_in = ~v.addr;
    for (int k = 1; k <= s + 1; k++) begin
      @(negedge clk);
      sample(v.inst);
      chk($sformatf("%s_rdy%0d", tag, k), 32'(s_ready), 32'(0));
      chk($sformatf("%s_done%0d", tag, k), 32'(s_done), 32'(k == s + 1));
      chk($sformatf("%s_err%0d", tag, k), 32'(s_err), 32'((k == s + 1) && v.e_err));
      chk($sformatf("%s_oe%0d", tag, k), 32'(s_oe), 32'(v.e_oe));
      chk($sformatf("%s_addr%0d", tag, k), 32'(s_addr), 32'(v.e_oe ? v.e_addr : 16'h0));
      chk($sformatf("%s_ld%0d", tag, k), 32'(s_ld), 32'(v.e_ld));
      chk($sformatf("%s_sel%0d", tag, k), 32'(s_sel), 32'(v.e_sel));
    end
    @(negedge clk);
    sample(v.inst);
    chk($sformatf("%s_rdy_back", tag), 32'(s_ready), 32'(1));
    chk($sformatf("%s_done_off", tag), 32'(s_done), 32'(0));
    chk($sformatf("%s_oe_off", tag), 32'(s_oe), 32'(0));
  endtask

  initial begin
    reset = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_z = 1'b0;
    req_op = '0; req_idx = '0; data_in = '0; addr_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample(i);
      chk($sformatf("rst%0d_rdy", i), 32'(s_ready), 32'(1));
      chk($sformatf("rst%0d_done", i), 32'(s_done), 32'(0));
      chk($sformatf("rst%0d_err", i), 32'(s_err), 32'(0));
      chk($sformatf("rst%0d_oe", i), 32'(s_oe), 32'(0));
      chk($sformatf("rst%0d_addr", i), 32'(s_addr), 32'(0));
      chk($sformatf("rst%0d_leds", i), 32'({s_ld, s_sel}), 32'(0));
    end

    //              inst op    idx   data   addr      err  oe   e_addr    ld       sel
    tbl.push_back(mk(0, 3'd0, 2'd1, 8'h34, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 3'd1, 2'd1, 8'h12, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 3'd3, 2'd1, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h1234, 4'b0000, 4'b0010));
    tbl.push_back(mk(0, 3'd2, 2'd0, 8'h00, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 3'd4, 2'd0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 3'd3, 2'd0, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 3'd7, 2'd1, 8'hAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 3'd3, 2'd1, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h1234, 4'b0000, 4'b0010));
    tbl.push_back(mk(0, 3'd2, 2'd3, 8'h00, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 3'd0, 2'd3, 8'h7E, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 3'd4, 2'd3, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 3'd3, 2'd3, 8'h00, 16'h0000, 1'b0, 1'b1, 16'hA57F, 4'b0000, 4'b1000));
    tbl.push_back(mk(1, 3'd2, 2'd2, 8'h00, 16'h1357, 1'b0, 1'b0, 16'h0000, 4'b0100, 4'b0000));
    tbl.push_back(mk(1, 3'd0, 2'd3, 8'h66, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 3'd3, 2'd3, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 3'd3, 2'd2, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h1357, 4'b0000, 4'b0100));
    tbl.push_back(mk(1, 3'd5, 2'd0, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 3'd3, 2'd0, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(2, 3'd0, 2'd2, 8'h99, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0100, 4'b0000));
    tbl.push_back(mk(2, 3'd3, 2'd2, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h0099, 4'b0000, 4'b0100));

    foreach (tbl[i]) run_op(tbl[i], $sformatf("v%0d", i));

    // req_valid held high: three INCs of reg1, one every four cycles
    @(negedge clk);
    req_op = 3'd4; req_idx = 2'd1;
    set_valid(0, 1'b1);
    dcount = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      sample(0);
      if (k == 12) set_valid(0, 1'b0);
      chk($sformatf("bb_done%0d", k), 32'(s_done), 32'((k % 4) == 3));
      chk($sformatf("bb_rdy%0d", k), 32'(s_ready), 32'((k % 4) == 0));
      if (s_done) dcount++;
    end
    chk("bb_count", 32'(dcount), 32'(3));
    run_op(mk(0, 3'd3, 2'd1, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h1237, 4'b0000, 4'b0010), "bb_sel");

    // reset during SETTLE of LOAD_ADDR idx2
    @(negedge clk);
    req_op = 3'd2; req_idx = 2'd2; addr_in = 16'hBEEF;
    set_valid(0, 1'b1);
    @(posedge clk);
    #1;
    set_valid(0, 1'b0);
    @(negedge clk);
    sample(0);
    chk("mid_ld", 32'(s_ld), 32'(4'b0100));
    reset = 1'b1;
    #1;
    sample(0);
    chk("mid_rst_rdy", 32'(s_ready), 32'(1));
    chk("mid_rst_ld", 32'(s_ld), 32'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      sample(0);
      if (s_done) dcount++;
    end
    chk("mid_no_done", 32'(dcount), 32'(0));
    run_op(mk(0, 3'd3, 2'd2, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0100), "post_sel2");
    run_op(mk(0, 3'd3, 2'd1, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0010), "post_sel1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
